operand_entry_fsm: RTL and testbench



---
 rtl/keypad_pkg.sv | 19 +
 rtl/hex_entry_reg.sv | 52 +++++
 rtl/operand_entry_fsm.sv | 155 +++++++++++++++
 tb/tb_operand_entry_fsm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions for the FPGA adder front end.
// Contents:
//   KEY_ENTER / KEY_CLEAR / KEY_ACCUM / KEY_FINISH : command key codes
//   (codes 0x00-0x0F are hex digits, codes above 0x13 are reserved)
//   entry_state_t : operand entry phases GET_A, GET_B, ACC
package keypad_pkg;

    localparam logic [4:0] KEY_ENTER  = 5'h10;
    localparam logic [4:0] KEY_CLEAR  = 5'h11;
    localparam logic [4:0] KEY_ACCUM  = 5'h12;
    localparam logic [4:0] KEY_FINISH = 5'h13;

    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        ACC   = 2'd2
    } entry_state_t;

endpackage

// File: rtl/hex_entry_reg.sv
// Digit shift register with saturating digit count for keypad entry.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   shift    : append digit as the new least-significant nibble (ignored when full)
//   clear    : empty the register (wins over shift)
//   digit    : hex digit to append
//   value    : digits typed so far, right-justified
//   count    : number of digits held, 0..DIGITS
//   full     : count has reached DIGITS
module hex_entry_reg #(
    parameter int DIGITS = 3,
    localparam int W     = 4 * DIGITS,
    localparam int CW    = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          shift,
    input  logic          clear,
    input  logic [3:0]    digit,
    output logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          full
);

    logic [W-1:0]  value_r;
    logic [CW-1:0] count_r;
    logic          full_s;

    assign full_s = (count_r == CW'(DIGITS));

    // Entry register: clear has priority, a shift into a full register is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= {W{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            value_r <= {W{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (shift && !full_s) begin
            value_r <= {value_r[W-5:0], digit};
            count_r <= count_r + CW'(1);
        end else begin
            value_r <= value_r;
            count_r <= count_r;
        end
    end

    assign value = value_r;
    assign count = count_r;
    assign full  = full_s;

endmodule

// File: rtl/operand_entry_fsm.sv
// Keypad operand entry controller feeding the arithmetic FSM of the adder.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   key_valid         : single-cycle strobe qualifying key_code
//   key_code          : 0x00-0x0F digit, 0x10 ENTER, 0x11 CLEAR, 0x12 ACCUM, 0x13 FINISH
//   num1_hex          : latched first operand
//   num2_hex          : latched second / accumulate operand
//   new_input         : one-cycle pulse, operands ready
//   finish_input      : one-cycle pulse, sequence ended
//   accumulate_enable : high while in the ACC phase
//   entry_value       : digits typed so far, right-justified
//   entry_count       : number of digits typed
//   key_reject        : one-cycle pulse, key ignored
module operand_entry_fsm
    import keypad_pkg::*;
#(
    parameter int DIGITS = 3,
    localparam int W     = 4 * DIGITS,
    localparam int CW    = $clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [4:0]    key_code,
    output logic [W-1:0]  num1_hex,
    output logic [W-1:0]  num2_hex,
    output logic          new_input,
    output logic          finish_input,
    output logic          accumulate_enable,
    output logic [W-1:0]  entry_value,
    output logic [CW-1:0] entry_count,
    output logic          key_reject
);

    entry_state_t  state_r, next_state_s;
    logic [W-1:0]  num1_r, num2_r;
    logic          new_r, fin_r, acc_r, rej_r;

    logic          shift_s, clear_s, latch1_s, latch2_s, new_s, fin_s, rej_s;
    logic [W-1:0]  entry_value_s;
    logic [CW-1:0] entry_count_s;
    logic          full_s, has_entry_s;

    hex_entry_reg #(.DIGITS(DIGITS)) u_entry (
        .clk   (clk),
        .rst   (rst),
        .shift (shift_s),
        .clear (clear_s),
        .digit (key_code[3:0]),
        .value (entry_value_s),
        .count (entry_count_s),
        .full  (full_s)
    );

    assign has_entry_s = (entry_count_s != {CW{1'b0}});

    // Key decode: turns one strobed key into entry-register and FSM actions.
    always_comb begin
        next_state_s = state_r;
        shift_s      = 1'b0;
        clear_s      = 1'b0;
        latch1_s     = 1'b0;
        latch2_s     = 1'b0;
        new_s        = 1'b0;
        fin_s        = 1'b0;
        rej_s        = 1'b0;
        if (!key_valid) begin
            next_state_s = state_r;
        end else if (key_code[4] == 1'b0) begin
            // Hex digit: a fourth digit is refused rather than scrolling the entry.
            if (full_s) begin
                rej_s = 1'b1;
            end else begin
                shift_s = 1'b1;
            end
        end else begin
            case (key_code)
                KEY_CLEAR: begin
                    clear_s = 1'b1;
                end
                KEY_ENTER: begin
                    if (!has_entry_s) begin
                        rej_s = 1'b1;
                    end else begin
                        case (state_r)
                            GET_A: begin
                                latch1_s     = 1'b1;
                                clear_s      = 1'b1;
                                next_state_s = GET_B;
                            end
                            GET_B: begin
                                latch2_s     = 1'b1;
                                new_s        = 1'b1;
                                clear_s      = 1'b1;
                                next_state_s = ACC;
                            end
                            default: begin
                                rej_s = 1'b1;
                            end
                        endcase
                    end
                end
                KEY_ACCUM: begin
                    if ((state_r == ACC) && has_entry_s) begin
                        latch2_s = 1'b1;
                        new_s    = 1'b1;
                        clear_s  = 1'b1;
                    end else begin
                        rej_s = 1'b1;
                    end
                end
                KEY_FINISH: begin
                    fin_s        = 1'b1;
                    clear_s      = 1'b1;
                    next_state_s = GET_A;
                end
                default: begin
                    rej_s = 1'b1;
                end
            endcase
        end
    end

    // FSM state and registered controls; pulses are rewritten every cycle so they last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= GET_A;
            num1_r  <= {W{1'b0}};
            num2_r  <= {W{1'b0}};
            new_r   <= 1'b0;
            fin_r   <= 1'b0;
            acc_r   <= 1'b0;
            rej_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            num1_r  <= latch1_s ? entry_value_s : num1_r;
            num2_r  <= latch2_s ? entry_value_s : num2_r;
            new_r   <= new_s;
            fin_r   <= fin_s;
            // Follows the next state so it rises together with the GET_B->ACC new_input pulse.
            acc_r   <= (next_state_s == ACC);
            rej_r   <= rej_s;
        end
    end

    assign num1_hex          = num1_r;
    assign num2_hex          = num2_r;
    assign new_input         = new_r;
    assign finish_input      = fin_r;
    assign accumulate_enable = acc_r;
    assign key_reject        = rej_r;
    assign entry_value       = entry_value_s;
    assign entry_count       = entry_count_s;

endmodule

// File: tb/tb_operand_entry_fsm.sv
module tb_operand_entry_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [11:0] num1_hex, num2_hex, entry_value;
    logic        new_input, finish_input, accumulate_enable, key_reject;
    logic [1:0]  entry_count;

    int n_cmp = 0;
    int n_bad = 0;

    operand_entry_fsm #(.DIGITS(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .key_valid         (key_valid),
        .key_code          (key_code),
        .num1_hex          (num1_hex),
        .num2_hex          (num2_hex),
        .new_input         (new_input),
        .finish_input      (finish_input),
        .accumulate_enable (accumulate_enable),
        .entry_value       (entry_value),
        .entry_count       (entry_count),
        .key_reject        (key_reject)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = first operand, 1 = second, 2 = accumulating.
    int          m_digits[$];
    int          m_phase;
    logic [11:0] m_num1, m_num2;
    logic        m_new, m_fin, m_rej;

    function automatic logic [11:0] m_entry();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return v[11:0];
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_phase = 0;
        m_num1 = 12'h000;
        m_num2 = 12'h000;
        m_new = 1'b0;
        m_fin = 1'b0;
        m_rej = 1'b0;
    endtask

    task automatic model_key(input logic v, input logic [4:0] c);
        int code;
        code = int'(c);
        m_new = 1'b0;
        m_fin = 1'b0;
        m_rej = 1'b0;
        if (v) begin
            if (code < 16) begin
                if (m_digits.size() < 3) m_digits.push_back(code);
                else m_rej = 1'b1;
            end else if (code == 16) begin
                if (m_digits.size() == 0 || m_phase == 2) m_rej = 1'b1;
                else if (m_phase == 0) begin
                    m_num1 = m_entry(); m_digits.delete(); m_phase = 1;
                end else begin
                    m_num2 = m_entry(); m_digits.delete(); m_phase = 2; m_new = 1'b1;
                end
            end else if (code == 17) begin
                m_digits.delete();
            end else if (code == 18) begin
                if (m_phase == 2 && m_digits.size() > 0) begin
                    m_num2 = m_entry(); m_digits.delete(); m_new = 1'b1;
                end else m_rej = 1'b1;
            end else if (code == 19) begin
                m_fin = 1'b1; m_digits.delete(); m_phase = 0;
            end else begin
                m_rej = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".num1"}, num1_hex, m_num1);
        chk({tag, ".num2"}, num2_hex, m_num2);
        chk({tag, ".value"}, entry_value, m_entry());
        chk({tag, ".count"}, 12'(entry_count), 12'(m_digits.size()));
        chk({tag, ".new"}, 12'(new_input), 12'(m_new));
        chk({tag, ".fin"}, 12'(finish_input), 12'(m_fin));
        chk({tag, ".acc"}, 12'(accumulate_enable), (m_phase == 2) ? 12'h001 : 12'h000);
        chk({tag, ".rej"}, 12'(key_reject), 12'(m_rej));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".num1"}, num1_hex, 12'h000);
        chk({tag, ".num2"}, num2_hex, 12'h000);
        chk({tag, ".value"}, entry_value, 12'h000);
        chk({tag, ".count"}, 12'(entry_count), 12'h000);
        chk({tag, ".new"}, 12'(new_input), 12'h000);
        chk({tag, ".fin"}, 12'(finish_input), 12'h000);
        chk({tag, ".acc"}, 12'(accumulate_enable), 12'h000);
        chk({tag, ".rej"}, 12'(key_reject), 12'h000);
    endtask

    // One cycle: drive away from the active edge, check 1 time unit after it.
    task automatic step(input logic v, input logic [4:0] c, input string tag);
        @(negedge clk);
        key_valid = v;
        key_code  = c;
        model_key(v, c);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic async_rst(input string tag);
        @(negedge clk);
        key_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_zero(tag);
        model_reset();
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  c;
        logic [11:0] n1, n2, ev;
        logic [1:0]  cnt;
        logic        nw, fn, ac, rj;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic v, input logic [4:0] c, input logic [11:0] n1, input logic [11:0] n2,
                       input logic [11:0] ev, input logic [1:0] cnt,
                       input logic nw, input logic fn, input logic ac, input logic rj);
        vec_t e;
        e.v = v; e.c = c; e.n1 = n1; e.n2 = n2; e.ev = ev; e.cnt = cnt;
        e.nw = nw; e.fn = fn; e.ac = ac; e.rj = rj;
        tab.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 5'h00;
        model_reset();

        //   v     code   num1     num2     value    cnt    new   fin   acc   rej
        add(1'b1, 5'h01, 12'h123 & 12'h000, 12'h000, 12'h001, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h02, 12'h000, 12'h000, 12'h012, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h03, 12'h000, 12'h000, 12'h123, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h10, 12'h123, 12'h000, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h04, 12'h123, 12'h000, 12'h004, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h05, 12'h123, 12'h000, 12'h045, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h10, 12'h123, 12'h045, 12'h000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 5'h10, 12'h123, 12'h045, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h07, 12'h123, 12'h045, 12'h007, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h12, 12'h123, 12'h007, 12'h000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h0F, 12'h123, 12'h007, 12'h00F, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h0F, 12'h123, 12'h007, 12'h0FF, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h0F, 12'h123, 12'h007, 12'hFFF, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h12, 12'h123, 12'hFFF, 12'h000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h13, 12'h123, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 5'h0A, 12'h123, 12'hFFF, 12'h00A, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h0B, 12'h123, 12'hFFF, 12'h0AB, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h0C, 12'h123, 12'hFFF, 12'hABC, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h0D, 12'h123, 12'hFFF, 12'hABC, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 5'h11, 12'h123, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h10, 12'h123, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 5'h09, 12'h123, 12'hFFF, 12'h009, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h08, 12'h123, 12'hFFF, 12'h098, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h11, 12'h123, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h14, 12'h123, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 5'h12, 12'h123, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 5'h13, 12'h123, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 5'h01, 12'h123, 12'hFFF, 12'h001, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h10, 12'h001, 12'hFFF, 12'h000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h02, 12'h001, 12'hFFF, 12'h002, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'h10, 12'h001, 12'h002, 12'h000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 5'h00, 12'h001, 12'h002, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h12, 12'h001, 12'h002, 12'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b1, 5'h03, 12'h001, 12'h002, 12'h003, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, 5'h10, 12'h001, 12'h002, 12'h003, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b1, 5'h13, 12'h001, 12'h002, 12'h000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tab.size(); i++) begin
            string tg;
            tg = $sformatf("vec%0d", i);
            step(tab[i].v, tab[i].c, {tg, ".model"});
            chk({tg, ".num1"}, num1_hex, tab[i].n1);
            chk({tg, ".num2"}, num2_hex, tab[i].n2);
            chk({tg, ".value"}, entry_value, tab[i].ev);
            chk({tg, ".count"}, 12'(entry_count), 12'(tab[i].cnt));
            chk({tg, ".new"}, 12'(new_input), 12'(tab[i].nw));
            chk({tg, ".fin"}, 12'(finish_input), 12'(tab[i].fn));
            chk({tg, ".acc"}, 12'(accumulate_enable), 12'(tab[i].ac));
            chk({tg, ".rej"}, 12'(key_reject), 12'(tab[i].rj));
        end

        // Reset between digits 5 and 6: the partial entry is lost.
        step(1'b1, 5'h05, "rstA.d5");
        async_rst("rstA");
        step(1'b1, 5'h06, "rstA.d6");
        chk("rstA.value6", entry_value, 12'h006);

        // Reset while accumulating: back to the first operand.
        step(1'b1, 5'h11, "rstB.clr");
        step(1'b1, 5'h01, "rstB.k1");
        step(1'b1, 5'h10, "rstB.e1");
        step(1'b1, 5'h02, "rstB.k2");
        step(1'b1, 5'h10, "rstB.e2");
        chk("rstB.in_acc", 12'(accumulate_enable), 12'h001);
        async_rst("rstB");
        step(1'b1, 5'h03, "rstB.k3");
        step(1'b1, 5'h10, "rstB.e3");
        chk("rstB.num1_after", num1_hex, 12'h003);
        chk("rstB.acc_after", 12'(accumulate_enable), 12'h000);

        // Randomized key streams against the reference model.
        for (int i = 0; i < 600; i++) begin
            logic       v;
            logic [4:0] c;
            int         r;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            c = (r < 10) ? 5'($urandom_range(0, 15)) : 5'(16 + (r - 10));
            step(v, c, "rand");
        end

        @(negedge clk);
        key_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
